// File: rtl/segment_descriptor_loader_if.sv
// Request, memory-read and result bundle of the segment descriptor loader.
// The loader takes the slave view; the requester/memory side takes the master view.
interface segment_descriptor_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  load_valid;
  logic                  load_ready;
  logic [2:0]            load_index;
  logic [15:0]           load_selector;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  logic                  seg_write_enable;
  logic [4:0]            seg_write_index;
  logic [15:0]           seg_write_data;

  logic                  desc_valid;
  logic [2:0]            desc_index;
  logic [31:0]           desc_base;
  logic [31:0]           desc_limit;
  logic [7:0]            desc_access;
  logic [3:0]            desc_flags;

  logic                  fault;
  logic [1:0]            fault_code;
  logic [15:0]           fault_selector;

  modport master (
    output load_valid, load_index, load_selector, mem_ack, mem_rdata,
    input  load_ready, mem_req, mem_addr,
    input  seg_write_enable, seg_write_index, seg_write_data,
    input  desc_valid, desc_index, desc_base, desc_limit, desc_access, desc_flags,
    input  fault, fault_code, fault_selector
  );

  modport slave (
    input  load_valid, load_index, load_selector, mem_ack, mem_rdata,
    output load_ready, mem_req, mem_addr,
    output seg_write_enable, seg_write_index, seg_write_data,
    output desc_valid, desc_index, desc_base, desc_limit, desc_access, desc_flags,
    output fault, fault_code, fault_selector
  );
endinterface

// File: rtl/segment_descriptor_loader.sv
// Loads a selector into a segment register and fills its descriptor cache, either
// directly (real mode) or by reading and checking the 8-byte GDT/LDT descriptor.
module segment_descriptor_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int SEG_COUNT  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  protected_mode,
  input  logic [ADDR_WIDTH-1:0] gdtr_base,
  input  logic [15:0]           gdtr_limit,
  input  logic [ADDR_WIDTH-1:0] ldtr_base,
  input  logic [15:0]           ldtr_limit,
  segment_descriptor_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    READ_LO = 3'd2,
    READ_HI = 3'd3,
    COMMIT  = 3'd4,
    FAULT   = 3'd5
  } state_e;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] limit;
    logic [7:0]  access;
    logic [3:0]  flags;
  } desc_t;

  localparam int unsigned SegCountU      = SEG_COUNT;
  localparam logic [1:0] FaultBadIndex   = 2'b00;
  localparam logic [1:0] FaultNullSel    = 2'b01;
  localparam logic [1:0] FaultTableLimit = 2'b10;
  localparam logic [1:0] FaultNotPresent = 2'b11;

  function automatic desc_t decode_desc(input logic [31:0] lo, input logic [31:0] hi);
    desc_t       d;
    logic [19:0] raw;
    raw      = {hi[19:16], lo[15:0]};
    d.base   = {hi[31:24], hi[7:0], lo[31:16]};
    d.limit  = hi[23] ? {raw, 12'hFFF} : {12'h000, raw};
    d.access = hi[15:8];
    d.flags  = hi[23:20];
    return d;
  endfunction

  state_e                state_q, state_d;
  logic [2:0]            index_q, index_d;
  logic [15:0]           sel_q, sel_d;
  logic                  pmode_q, pmode_d;
  logic [31:0]           lo_q, lo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic        load_ready_q, load_ready_d;
  logic        mem_req_q, mem_req_d;
  logic        seg_we_q, seg_we_d;
  logic [4:0]  seg_idx_q, seg_idx_d;
  logic [15:0] seg_data_q, seg_data_d;
  logic        desc_valid_q, desc_valid_d;
  logic [2:0]  desc_index_q, desc_index_d;
  desc_t       desc_q, desc_d;
  logic        fault_q, fault_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [15:0] fault_sel_q, fault_sel_d;

  logic [15:0]           offset_s;
  logic [ADDR_WIDTH-1:0] table_base_s;
  logic [15:0]           table_limit_s;
  logic                  limit_over_s;
  logic                  null_sel_s;
  logic                  bad_index_s;

  assign offset_s      = {sel_q[15:3], 3'b000};
  assign table_base_s  = sel_q[2] ? ldtr_base : gdtr_base;
  assign table_limit_s = sel_q[2] ? ldtr_limit : gdtr_limit;
  assign limit_over_s  = ({1'b0, offset_s} + 17'd7) > {1'b0, table_limit_s};
  assign null_sel_s    = (sel_q[15:2] == 14'd0);
  assign bad_index_s   = ({29'd0, index_q} >= SegCountU);

  // Next-state, request latching, address sequencing and descriptor selection.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    sel_d        = sel_q;
    pmode_d      = pmode_q;
    lo_d         = lo_q;
    addr_d       = addr_q;
    desc_d       = '0;
    fault_code_d = FaultBadIndex;
    case (state_q)
      IDLE: begin
        if (bus.load_valid && load_ready_q) begin
          index_d = bus.load_index;
          sel_d   = bus.load_selector;
          pmode_d = protected_mode;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (bad_index_s) begin
          state_d      = FAULT;
          fault_code_d = FaultBadIndex;
        end else if (!pmode_q) begin
          state_d       = COMMIT;
          desc_d.base   = {12'h000, sel_q, 4'h0};
          desc_d.limit  = 32'h0000_FFFF;
          desc_d.access = 8'h93;
        end else if (null_sel_s) begin
          if (index_q <= 3'd1) begin
            state_d      = FAULT;
            fault_code_d = FaultNullSel;
          end else begin
            state_d = COMMIT;
          end
        end else if (limit_over_s) begin
          state_d      = FAULT;
          fault_code_d = FaultTableLimit;
        end else begin
          state_d = READ_LO;
          addr_d  = table_base_s + ADDR_WIDTH'(offset_s);
        end
      end
      READ_LO: begin
        if (bus.mem_ack) begin
          lo_d    = bus.mem_rdata;
          addr_d  = addr_q + ADDR_WIDTH'(3'd4);
          state_d = READ_HI;
        end else begin
          state_d = READ_LO;
        end
      end
      READ_HI: begin
        if (bus.mem_ack) begin
          // Present bit lives at bit 15 of the high descriptor word.
          if (!bus.mem_rdata[15]) begin
            state_d      = FAULT;
            fault_code_d = FaultNotPresent;
          end else begin
            state_d = COMMIT;
            desc_d  = decode_desc(lo_q, bus.mem_rdata);
          end
        end else begin
          state_d = READ_HI;
        end
      end
      COMMIT:  state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output strobes are derived from the next state so they register in step with it.
  always_comb begin
    load_ready_d = (state_d == IDLE);
    mem_req_d    = (state_d == READ_LO) || (state_d == READ_HI);
    if (state_d == COMMIT) begin
      seg_we_d     = 1'b1;
      seg_idx_d    = {2'b00, index_q};
      seg_data_d   = sel_q;
      desc_valid_d = 1'b1;
      desc_index_d = index_q;
    end else begin
      seg_we_d     = 1'b0;
      seg_idx_d    = 5'd0;
      seg_data_d   = 16'd0;
      desc_valid_d = 1'b0;
      desc_index_d = 3'd0;
    end
    if (state_d == FAULT) begin
      fault_d     = 1'b1;
      fault_sel_d = sel_q;
    end else begin
      fault_d     = 1'b0;
      fault_sel_d = 16'd0;
    end
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      index_q      <= 3'd0;
      sel_q        <= 16'd0;
      pmode_q      <= 1'b0;
      lo_q         <= 32'd0;
      addr_q       <= '0;
      load_ready_q <= 1'b1;
      mem_req_q    <= 1'b0;
      seg_we_q     <= 1'b0;
      seg_idx_q    <= 5'd0;
      seg_data_q   <= 16'd0;
      desc_valid_q <= 1'b0;
      desc_index_q <= 3'd0;
      desc_q       <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
      fault_sel_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      sel_q        <= sel_d;
      pmode_q      <= pmode_d;
      lo_q         <= lo_d;
      addr_q       <= addr_d;
      load_ready_q <= load_ready_d;
      mem_req_q    <= mem_req_d;
      seg_we_q     <= seg_we_d;
      seg_idx_q    <= seg_idx_d;
      seg_data_q   <= seg_data_d;
      desc_valid_q <= desc_valid_d;
      desc_index_q <= desc_index_d;
      desc_q       <= desc_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      fault_sel_q  <= fault_sel_d;
    end
  end

  assign bus.load_ready       = load_ready_q;
  assign bus.mem_req          = mem_req_q;
  assign bus.mem_addr         = addr_q;
  assign bus.seg_write_enable = seg_we_q;
  assign bus.seg_write_index  = seg_idx_q;
  assign bus.seg_write_data   = seg_data_q;
  assign bus.desc_valid       = desc_valid_q;
  assign bus.desc_index       = desc_index_q;
  assign bus.desc_base        = desc_q.base;
  assign bus.desc_limit       = desc_q.limit;
  assign bus.desc_access      = desc_q.access;
  assign bus.desc_flags       = desc_q.flags;
  assign bus.fault            = fault_q;
  assign bus.fault_code       = fault_code_q;
  assign bus.fault_selector   = fault_sel_q;

endmodule

// File: tb/tb_segment_descriptor_loader.sv
// Self-checking bench: directed scenarios plus randomized loads checked against
// a descriptor-table reference model, with a memory responder of variable latency.
module tb_segment_descriptor_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        protected_mode;
  logic [31:0] gdtr_base, ldtr_base;
  logic [15:0] gdtr_limit, ldtr_limit;

  int errors = 0;
  int checks = 0;

  bit [31:0]   mem_model [bit [31:0]];
  int          wait_cycles = 0;
  bit          stray_ack = 1'b0;
  bit          req_seen = 1'b0;
  logic [31:0] ack_addrs [$];

  typedef struct {
    bit          fault;
    logic [1:0]  code;
    logic [31:0] base, limit;
    logic [7:0]  access;
    logic [3:0]  flags;
    int          lat;
    bit          reads;
    logic [31:0] addr0, addr1;
    logic [15:0] fsel;
    logic [4:0]  seg_idx;
    logic [15:0] seg_data;
    logic [2:0]  desc_index;
    bit          seg_we, desc_valid, ready_at_strobe, clean, timeout;
  } res_t;

  segment_descriptor_loader_if #(.ADDR_WIDTH(32)) bus ();

  segment_descriptor_loader #(.ADDR_WIDTH(32), .SEG_COUNT(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .protected_mode (protected_mode),
    .gdtr_base      (gdtr_base),
    .gdtr_limit     (gdtr_limit),
    .ldtr_base      (ldtr_base),
    .ldtr_limit     (ldtr_limit),
    .bus            (bus)
  );

  always #5 clock = ~clock;

  function automatic bit [31:0] mem_read(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'd0;
  endfunction

  // Reference: outcome of a load from the selector rules and table contents.
  function automatic res_t model(input logic [2:0] idx, input logic [15:0] sel, input bit pm, input int waits);
    res_t            r;
    longint unsigned off, lim, raw;
    logic [31:0]     tbase, lo, hi;
    r = '{default: 0};
    r.lat = 2;
    if (idx >= 3'd6) begin r.fault = 1'b1; r.code = 2'd0; return r; end
    if (!pm) begin
      r.base = 32'(sel) * 32'd16; r.limit = 32'd65535; r.access = 8'h93;
      return r;
    end
    if (sel < 16'd4) begin
      if (idx < 3'd2) begin r.fault = 1'b1; r.code = 2'd1; end
      return r;
    end
    off   = longint'(sel / 16'd8) * 8;
    lim   = sel[2] ? ldtr_limit : gdtr_limit;
    tbase = sel[2] ? ldtr_base : gdtr_base;
    if (off + 7 > lim) begin r.fault = 1'b1; r.code = 2'd2; return r; end
    r.reads = 1'b1;
    r.addr0 = tbase + 32'(off);
    r.addr1 = r.addr0 + 32'd4;
    lo = mem_read(r.addr0);
    hi = mem_read(r.addr1);
    r.lat = 4 + 2 * waits;
    if (hi[15] == 1'b0) begin r.fault = 1'b1; r.code = 2'd3; return r; end
    r.base   = (hi & 32'hFF00_0000) | ((hi & 32'h0000_00FF) << 16) | (lo >> 16);
    raw      = ((hi >> 16) & 32'hF) * 65536 + (lo & 32'hFFFF);
    r.limit  = hi[23] ? 32'(raw * 4096 + 4095) : 32'(raw);
    r.access = 8'(hi >> 8);
    r.flags  = 4'(hi >> 20);
    return r;
  endfunction

  // Memory responder: acks after wait_cycles idle cycles, checks address hold.
  initial begin : responder
    int          waited;
    logic [31:0] held;
    waited = 0; held = 32'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clock);
      if (reset && bus.mem_req) begin
        req_seen = 1'b1;
        if (waited == 0) begin
          held = bus.mem_addr;
        end else begin
          checks++;
          if (bus.mem_addr !== held) begin errors++; $display("FAIL addr_stable: got %h want %h", bus.mem_addr, held); end
        end
        if (waited >= wait_cycles) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = mem_read(bus.mem_addr);
          ack_addrs.push_back(bus.mem_addr); waited = 0;
        end else begin
          bus.mem_ack = 1'b0; bus.mem_rdata = $urandom; waited++;
        end
      end else begin
        waited = 0;
        bus.mem_ack = stray_ack && ($urandom_range(0, 1) == 1);
        bus.mem_rdata = $urandom;
      end
    end
  end

  task automatic run_load(input logic [2:0] idx, input logic [15:0] sel, input bit pm, input int waits, output res_t o);
    o = '{default: 0};
    wait_cycles = waits;
    ack_addrs.delete();
    @(negedge clock);
    for (int k = 0; k < 20; k++) begin
      if (bus.load_ready) break;
      @(negedge clock);
    end
    req_seen = 1'b0;
    bus.load_valid = 1'b1; bus.load_index = idx; bus.load_selector = sel; protected_mode = pm;
    @(posedge clock);
    #1;
    bus.load_valid = 1'b0;
    protected_mode = ($urandom_range(0, 1) == 1);
    o.timeout = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (bus.seg_write_enable || bus.fault) begin
        o.timeout = 1'b0; o.lat = k; o.fault = bus.fault; o.code = bus.fault_code;
        o.fsel = bus.fault_selector; o.base = bus.desc_base; o.limit = bus.desc_limit;
        o.access = bus.desc_access; o.flags = bus.desc_flags; o.seg_we = bus.seg_write_enable;
        o.desc_valid = bus.desc_valid; o.seg_idx = bus.seg_write_index; o.seg_data = bus.seg_write_data;
        o.desc_index = bus.desc_index; o.ready_at_strobe = bus.load_ready;
        break;
      end
    end
    o.reads = req_seen;
    if (ack_addrs.size() > 0) o.addr0 = ack_addrs[0];
    if (ack_addrs.size() > 1) o.addr1 = ack_addrs[1];
    @(negedge clock);
    o.clean = !bus.seg_write_enable && !bus.fault && !bus.desc_valid && bus.load_ready;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.load_ready); end
    checks++; if ({bus.mem_req, bus.seg_write_enable, bus.desc_valid, bus.fault} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {bus.mem_req, bus.seg_write_enable, bus.desc_valid, bus.fault}); end
    checks++; if ({bus.mem_addr, bus.desc_base, bus.desc_limit} !== 96'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {bus.mem_addr, bus.desc_base, bus.desc_limit}); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.load_ready); end
  endtask

  task automatic test_real_mode();
    res_t o;
    stray_ack = 1'b1;
    run_load(3'd2, 16'h1234, 1'b0, 0, o);
    stray_ack = 1'b0;
    checks++; if (o.timeout || o.lat != 2) begin errors++; $display("FAIL real_latency: got %0d (timeout %0d) want 2", o.lat, o.timeout); end
    checks++; if ({o.seg_we, o.desc_valid, o.fault} !== 3'b110) begin errors++; $display("FAIL real_strobes: got %b want 110", {o.seg_we, o.desc_valid, o.fault}); end
    checks++; if (o.seg_idx !== 5'd2 || o.seg_data !== 16'h1234 || o.desc_index !== 3'd2) begin errors++; $display("FAIL real_seg: got %h/%h/%h want 02/1234/2", o.seg_idx, o.seg_data, o.desc_index); end
    checks++; if (o.base !== 32'h0001_2340 || o.limit !== 32'h0000_FFFF) begin errors++; $display("FAIL real_base_limit: got %h/%h want 00012340/0000ffff", o.base, o.limit); end
    checks++; if (o.access !== 8'h93 || o.flags !== 4'h0) begin errors++; $display("FAIL real_access: got %h/%h want 93/0", o.access, o.flags); end
    checks++; if (o.reads !== 1'b0 || o.clean !== 1'b1) begin errors++; $display("FAIL real_noreq_clean: got %b/%b want 0/1", o.reads, o.clean); end
  endtask

  task automatic test_protected();
    res_t o;
    gdtr_base = 32'h0000_1000; gdtr_limit = 16'h00FF;
    mem_model[32'h1010] = 32'h0000_FFFF; mem_model[32'h1014] = 32'h00CF_9A00;
    run_load(3'd0, 16'h0010, 1'b1, 0, o);
    checks++; if (o.timeout || o.lat != 4) begin errors++; $display("FAIL prot_latency: got %0d (timeout %0d) want 4", o.lat, o.timeout); end
    checks++; if (o.addr0 !== 32'h1010 || o.addr1 !== 32'h1014) begin errors++; $display("FAIL prot_addr: got %h/%h want 1010/1014", o.addr0, o.addr1); end
    checks++; if (o.base !== 32'd0 || o.limit !== 32'hFFFF_FFFF) begin errors++; $display("FAIL prot_base_limit: got %h/%h want 0/ffffffff", o.base, o.limit); end
    checks++; if (o.access !== 8'h9A || o.flags !== 4'hC) begin errors++; $display("FAIL prot_access: got %h/%h want 9a/c", o.access, o.flags); end
    checks++; if ({o.seg_we, o.desc_valid, o.fault, o.clean} !== 4'b1101) begin errors++; $display("FAIL prot_strobes: got %b want 1101", {o.seg_we, o.desc_valid, o.fault, o.clean}); end
  endtask

  task automatic test_null();
    res_t o;
    stray_ack = 1'b1;
    run_load(3'd1, 16'h0003, 1'b1, 0, o);
    checks++; if (o.timeout || o.fault !== 1'b1 || o.code !== 2'b01 || o.lat != 2) begin errors++; $display("FAIL null_ss_fault: got f=%b c=%b lat=%0d want f=1 c=01 lat=2", o.fault, o.code, o.lat); end
    checks++; if (o.seg_we !== 1'b0 || o.desc_valid !== 1'b0 || o.fsel !== 16'h0003) begin errors++; $display("FAIL null_ss_nowrite: got we=%b dv=%b sel=%h want 0/0/0003", o.seg_we, o.desc_valid, o.fsel); end
    run_load(3'd3, 16'h0003, 1'b1, 0, o);
    stray_ack = 1'b0;
    checks++; if (o.timeout || o.seg_we !== 1'b1 || o.fault !== 1'b0 || o.lat != 2) begin errors++; $display("FAIL null_es_commit: got we=%b f=%b lat=%0d want 1/0/2", o.seg_we, o.fault, o.lat); end
    checks++; if ({o.base, o.limit, o.access, o.flags} !== 76'd0 || o.reads !== 1'b0) begin errors++; $display("FAIL null_es_zero: got %h/%h/%h/%h req=%b want zeros", o.base, o.limit, o.access, o.flags, o.reads); end
  endtask

  task automatic test_table_limit();
    res_t o;
    ldtr_base = 32'h0000_8000; ldtr_limit = 16'h00FF;
    run_load(3'd2, 16'h0104, 1'b1, 0, o);
    checks++; if (o.timeout || o.fault !== 1'b1 || o.code !== 2'b10) begin errors++; $display("FAIL limit_fault: got f=%b c=%b want 1/10", o.fault, o.code); end
    checks++; if (o.reads !== 1'b0 || o.seg_we !== 1'b0 || o.fsel !== 16'h0104) begin errors++; $display("FAIL limit_noreq: got req=%b we=%b sel=%h want 0/0/0104", o.reads, o.seg_we, o.fsel); end
  endtask

  task automatic test_not_present();
    res_t o;
    gdtr_base = 32'h0000_3000; gdtr_limit = 16'h0FFF;
    mem_model[32'h3018] = 32'h1234_5678; mem_model[32'h301C] = 32'h00CF_1A00;
    run_load(3'd4, 16'h0018, 1'b1, 3, o);
    checks++; if (o.timeout || o.fault !== 1'b1 || o.code !== 2'b11 || o.lat != 10) begin errors++; $display("FAIL np_fault: got f=%b c=%b lat=%0d want 1/11/10", o.fault, o.code, o.lat); end
    checks++; if (o.seg_we !== 1'b0 || o.addr0 !== 32'h3018 || o.addr1 !== 32'h301C) begin errors++; $display("FAIL np_addr: got we=%b %h/%h want 0 3018/301c", o.seg_we, o.addr0, o.addr1); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    gdtr_base = 32'h0000_2000; gdtr_limit = 16'hFFFF;
    mem_model[32'h2008] = 32'h0000_1234; mem_model[32'h200C] = 32'h0000_9300;
    wait_cycles = 5; ack_addrs.delete();
    @(negedge clock);
    bus.load_valid = 1'b1; bus.load_index = 3'd2; bus.load_selector = 16'h0008; protected_mode = 1'b1;
    @(posedge clock);
    #1 bus.load_valid = 1'b0;
    for (int k = 0; k < 40 && ack_addrs.size() == 0; k++) @(negedge clock);
    @(negedge clock); @(negedge clock);
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_inflight: got %b want 1", bus.mem_req); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.seg_write_enable !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got req=%b we=%b want 0/0", bus.mem_req, bus.seg_write_enable); end
    seen = 1'b0;
    repeat (3) begin @(negedge clock); seen |= bus.seg_write_enable | bus.desc_valid; end
    reset = 1'b1;
    repeat (6) begin @(negedge clock); seen |= bus.seg_write_enable | bus.desc_valid | bus.mem_req; end
    checks++; if (seen !== 1'b0 || bus.load_ready !== 1'b1) begin errors++; $display("FAIL rstmid_nocommit: got activity=%b ready=%b want 0/1", seen, bus.load_ready); end
  endtask

  task automatic test_bad_index();
    res_t o;
    run_load(3'd6, 16'h0010, 1'b1, 0, o);
    checks++; if (o.timeout || o.fault !== 1'b1 || o.code !== 2'b00 || o.lat != 2) begin errors++; $display("FAIL badidx_fault: got f=%b c=%b lat=%0d want 1/00/2", o.fault, o.code, o.lat); end
    checks++; if (o.seg_we !== 1'b0 || o.reads !== 1'b0) begin errors++; $display("FAIL badidx_nowrite: got we=%b req=%b want 0/0", o.seg_we, o.reads); end
  endtask

  task automatic test_random();
    res_t        o, e;
    logic [2:0]  idx;
    logic [15:0] sel;
    logic [31:0] a, hi;
    bit          pm;
    int          waits;
    for (int n = 0; n < 40; n++) begin
      idx   = 3'($urandom_range(0, 7));
      pm    = ($urandom_range(0, 3) != 0);
      waits = $urandom_range(0, 3);
      sel   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      gdtr_base  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
      ldtr_base  = $urandom;
      gdtr_limit = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom_range(0, 16'h0800));
      ldtr_limit = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom_range(0, 16'h0800));
      a  = (sel[2] ? ldtr_base : gdtr_base) + {16'd0, sel[15:3], 3'b000};
      hi = $urandom;
      hi[15] = ($urandom_range(0, 3) != 0);
      mem_model[a] = $urandom; mem_model[a + 32'd4] = hi;
      stray_ack = ($urandom_range(0, 1) == 1);
      e = model(idx, sel, pm, waits);
      run_load(idx, sel, pm, waits, o);
      checks++; if (o.timeout !== 1'b0 || o.lat != e.lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d (timeout %0d) want %0d", n, o.lat, o.timeout, e.lat); end
      checks++; if (o.fault !== e.fault || o.seg_we !== !e.fault || o.desc_valid !== !e.fault) begin errors++; $display("FAIL rand_kind[%0d]: got f=%b we=%b dv=%b want f=%b", n, o.fault, o.seg_we, o.desc_valid, e.fault); end
      if (e.fault) begin
        checks++; if (o.code !== e.code || o.fsel !== sel) begin errors++; $display("FAIL rand_fault[%0d]: got %b/%h want %b/%h", n, o.code, o.fsel, e.code, sel); end
      end else begin
        checks++; if (o.seg_idx !== {2'b00, idx} || o.seg_data !== sel || o.desc_index !== idx) begin errors++; $display("FAIL rand_seg[%0d]: got %h/%h/%h want %h/%h/%h", n, o.seg_idx, o.seg_data, o.desc_index, idx, sel, idx); end
        checks++; if (o.base !== e.base || o.limit !== e.limit) begin errors++; $display("FAIL rand_base_limit[%0d]: got %h/%h want %h/%h", n, o.base, o.limit, e.base, e.limit); end
        checks++; if (o.access !== e.access || o.flags !== e.flags) begin errors++; $display("FAIL rand_access[%0d]: got %h/%h want %h/%h", n, o.access, o.flags, e.access, e.flags); end
      end
      checks++; if (o.reads !== e.reads) begin errors++; $display("FAIL rand_reads[%0d]: got %b want %b", n, o.reads, e.reads); end
      if (e.reads) begin
        checks++; if (o.addr0 !== e.addr0 || o.addr1 !== e.addr1) begin errors++; $display("FAIL rand_addr[%0d]: got %h/%h want %h/%h", n, o.addr0, o.addr1, e.addr0, e.addr1); end
      end
      checks++; if (o.ready_at_strobe !== 1'b0 || o.clean !== 1'b1) begin errors++; $display("FAIL rand_handshake[%0d]: got ready=%b clean=%b want 0/1", n, o.ready_at_strobe, o.clean); end
    end
    stray_ack = 1'b0;
  endtask

  initial begin
    bus.load_valid = 1'b0; bus.load_index = 3'd0; bus.load_selector = 16'd0;
    protected_mode = 1'b0; reset = 1'b0;
    gdtr_base = 32'd0; gdtr_limit = 16'd0; ldtr_base = 32'd0; ldtr_limit = 16'd0;
    test_reset();
    test_real_mode();
    test_protected();
    test_null();
    test_table_limit();
    test_not_present();
    test_reset_mid();
    test_bad_index();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/segment_descriptor_loader.md
Name: segment_descriptor_loader

Overview:
- Sequencer that loads a new selector into one of the six segment registers (CS, SS, DS, ES, FS, GS) and fetches the matching descriptor cache contents.
- Drives the segment register write port: write enable, 5-bit index, 16-bit data.
- Real mode: computes base/limit directly. Protected mode: reads the 8-byte descriptor from GDT/LDT over a req/ack memory port, checks it, then commits or faults.

Parameters:
ADDR_WIDTH, 32, linear address width of the memory port and of table bases
SEG_COUNT, 6, number of valid segment indices (0=CS,1=SS,2=DS,3=ES,4=FS,5=GS)

Ports:
clock  input  1  clock
reset  input  1  asynchronous, active-low reset
protected_mode  input  1  CR0.PE, sampled at request acceptance
load_valid  input  1  load request
load_ready  output  1  loader idle, can accept
load_index  input  3  target segment index
load_selector  input  16  new selector value
gdtr_base  input  ADDR_WIDTH  GDT base
gdtr_limit  input  16  GDT limit
ldtr_base  input  ADDR_WIDTH  LDT base
ldtr_limit  input  16  LDT limit
mem_req  output  1  memory read request
mem_addr  output  ADDR_WIDTH  read address, stable while mem_req=1
mem_ack  input  1  read data valid this cycle
mem_rdata  input  32  read data
seg_write_enable  output  1  one-cycle write strobe to segment register file
seg_write_index  output  5  {2'b00, load_index}
seg_write_data  output  16  selector
desc_valid  output  1  one-cycle descriptor cache update strobe
desc_index  output  3  segment index of update
desc_base  output  32  segment base
desc_limit  output  32  byte-granular limit
desc_access  output  8  access byte
desc_flags  output  4  {G, D/B, L, AVL}
fault  output  1  one-cycle fault strobe
fault_code  output  2  00 bad index, 01 null CS/SS, 10 table limit, 11 not present
fault_selector  output  16  offending selector

Behaviour:
- Reset (async, low): state IDLE; load_ready=1; all other outputs 0. Reset mid-operation aborts; mem_req drops immediately; no commit.
- States: IDLE, CHECK, READ_LO, READ_HI, COMMIT, FAULT.
- IDLE: load_ready=1. Accept on load_valid&load_ready; latch index, selector, protected_mode. Go to CHECK.
- CHECK, evaluated in this priority order:
  - index>=SEG_COUNT -> FAULT, code 00.
  - Real mode -> COMMIT with base={12'h0,sel,4'h0}, limit=32'h0000FFFF, access=8'h93, flags=0.
  - Null selector (sel[15:2]==0):
    - index 0 or 1 -> FAULT, code 01.
    - Otherwise -> COMMIT with base/limit/access/flags=0.
  - Table select: sel[2]=1 uses LDT, else GDT. Offset={sel[15:3],3'b000}.
  - offset+7 > table limit, 17-bit compare -> FAULT, code 10.
  - Otherwise -> READ_LO, mem_addr=base+offset.
- READ_LO: mem_req=1, hold address. On mem_ack, capture lo=mem_rdata, mem_addr+=4, go to READ_HI. mem_req stays high.
- READ_HI: on mem_ack, capture hi.
  - hi[15]=0 -> FAULT, code 11.
  - Else -> COMMIT.
  - mem_req=0 from the next cycle.
- Descriptor assembly:
  - base={hi[31:24],hi[7:0],lo[31:16]}.
  - raw={hi[19:16],lo[15:0]}.
  - limit = hi[23] ? {raw,12'hFFF} : {12'h0,raw}.
  - access=hi[15:8]; flags=hi[23:20].
- COMMIT (1 cycle): seg_write_enable=1 and desc_valid=1 together; desc_* and seg_write_* valid only in this cycle. Next state IDLE.
- FAULT (1 cycle): fault=1 with code/selector; no segment write, no desc_valid. Next state IDLE.
- Latency from acceptance cycle:
  - Real mode: COMMIT at +2.
  - Protected mode, zero-wait ack: COMMIT at +4.
  - Each wait cycle on mem_ack adds 1.
- New request accepted no earlier than the cycle after COMMIT/FAULT.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- mem_ack outside READ_LO/READ_HI is ignored.

Test Plan:
- Real mode, index 2, sel 16'h1234 -> COMMIT at +2: seg_write_index=2, data 16'h1234, desc_base=32'h00012340, desc_limit=32'h0000FFFF, access 8'h93.
- Protected mode, GDT base 32'h1000, limit 16'h00FF, sel 16'h0010, lo=32'h0000FFFF, hi=32'h00CF9A00, zero-wait -> addr 32'h1010 then 32'h1014; COMMIT at +4: base 0, limit 32'hFFFFFFFF, access 8'h9A, flags 4'hC.
- Null selector 16'h0003: index 1 -> fault code 01, no seg write; index 3 -> COMMIT with base/limit 0, no mem_req.
- LDT sel 16'h0104, ldtr_limit 16'h00FF -> offset 16'h0100 exceeds limit -> fault code 10, mem_req never asserted.
- Descriptor hi[15]=0, mem_ack delayed 3 cycles per word -> mem_addr stable during waits; fault code 11 at +10.
- Reset asserted in READ_HI -> mem_req=0 immediately; no seg_write_enable; load_ready=1 after release; index 6 request -> fault code 00.
